sw_debounce: RTL and testbench

Input-conditioning stage that sits directly upstream of the picoMIPS CPU top level and drives its 10-bit switch input bus. It synchronises each raw board switch into the `clk` domain and debounces it with a per-bit stability counter. It presents clean switch levels plus single-cycle rise/fall strobes for each bit. A CPU polling a switch then sees each press exactly once, and reset (SW[9]) never glitches.

---
 rtl/sw_debounce.sv | 165 ++++++++++++++++
 tb/tb_sw_debounce.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//
// Conditions the raw board switches before they reach the picoMIPS CPU `SW`
// port. Each bit is passed through a two-flop synchroniser into the `clk`
// domain. A per-bit stability counter then accepts a new level only after it
// has been seen for DB_CYCLES consecutive cycles. Clean levels are presented
// together with one-cycle rise/fall strobes, so a polling CPU sees each press
// exactly once and the reset switch (SW[9]) never glitches.
//
// Configuration macro: SW_DEBOUNCE_EN
//   defined   : full debounce with per-bit stability counters.
//   undefined : counters are not built. sw_out follows the synchronised input
//               every edge, which is intended for fast CPU program simulation.
//               DB_CYCLES and CNT_W are then only range-checked.
//
// Parameters
//   N_SW      : number of switch bits conditioned (default 10)
//   DB_CYCLES : consecutive stable cycles needed to accept a level (>= 2)
//   CNT_W     : width of each per-bit stability counter
//
// Ports
//   clk      in  1     system clock, rising-edge active
//   n_reset  in  1     asynchronous active-low reset, clears all state
//   sw_raw   in  N_SW  unsynchronised switch levels from the board pins
//   sw_out   out N_SW  debounced switch levels (to CPU SW port)
//   sw_rise  out N_SW  one-cycle strobe in the cycle sw_out[i] goes 0->1
//   sw_fall  out N_SW  one-cycle strobe in the cycle sw_out[i] goes 1->0
//   stable   out 1     high when no bit has a pending (counting) mismatch
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int N_SW      = 10,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_out,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            stable
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity. A count of 1 would make the counter
  // zero bits wide, and the counter must be able to hold DB_CYCLES-1.
  // -------------------------------------------------------------------------
  if ((DB_CYCLES < 2) || (CNT_W < 1) || ((2 ** CNT_W) < DB_CYCLES)) begin : g_bad_cfg
    $error("sw_debounce: DB_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  // -------------------------------------------------------------------------
  // Synchroniser. s1 may go metastable; only s2 is used downstream.
  // -------------------------------------------------------------------------
  logic [N_SW-1:0] s1_q, s1_d;
  logic [N_SW-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = sw_raw;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // -------------------------------------------------------------------------
  // Debounced level and edge strobes.
  // -------------------------------------------------------------------------
  logic [N_SW-1:0] out_q, out_d;
  logic [N_SW-1:0] rise_q, rise_d;
  logic [N_SW-1:0] fall_q, fall_d;
  logic            stable_w;

`ifdef SW_DEBOUNCE_EN

  // Per-bit stability counters, packed so they reset and update as one
  // vector. A counter only advances while s2 disagrees with sw_out, and it
  // is cleared on the cycle the new level is accepted. It therefore tops out
  // at DB_CYCLES-1 and can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (s2_q[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // The DB_CYCLES-th consecutive mismatch: accept the new level.
          out_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // A single cycle of agreement leaves cnt_d[i] at its zero default.
    end
  end

  // Quiet only when every counter is idle and every bit already agrees.
  // Both terms are needed: a counter can be non-zero for one cycle after
  // the input has already returned to the accepted level.
  always_comb begin
    stable_w = 1'b1;
    for (int i = 0; i < N_SW; i++) begin
      if ((cnt_q[i] != '0) || (s2_q[i] != out_q[i])) begin
        stable_w = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`else

  // Pass-through build: the synchronised level is accepted every edge.
  always_comb begin
    out_d    = s2_q;
    stable_w = (s2_q == out_q);
  end

`endif

  // Strobes are registered alongside sw_out, so they are high in exactly
  // the cycle the level changes. A bit cannot both rise and fall at once.
  always_comb begin
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sw_out  = out_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  assign stable  = stable_w;

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//
// Directed bench for sw_debounce at DB_CYCLES=4. A reference model predicts
// the outputs from the behavioural rule: a bit flips once its last W
// synchronised samples all differ from the accepted level. W is DB_CYCLES
// with SW_DEBOUNCE_EN defined and 1 without it. The model is compared every
// cycle, and literal expectations pin reset, latency and the edge cases.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

  localparam int N  = 10;
  localparam int DB = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int W   = DB;
  localparam int LAT = DB + 1;
`else
  localparam int W   = 1;
  localparam int LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         n_reset = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_out, sw_rise, sw_fall;
  logic         stable;

  always #5 clk = ~clk;

  sw_debounce #(.N_SW(N), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .sw_raw  (sw_raw),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .stable  (stable)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
  logic [N-1:0] exp_q[$];   // synchronised samples seen at the last W edges

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      exp_q.delete();
      for (int k = 0; k < W; k++) exp_q.push_back('0);
    end else begin
      logic [N-1:0] nxt;
      nxt = m_out;
      exp_q.push_back(m_s2);
      if (exp_q.size() > W) void'(exp_q.pop_front());
      for (int i = 0; i < N; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        foreach (exp_q[j]) if (exp_q[j][i] == m_out[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_out[i];
      end
      m_rise = nxt & ~m_out;
      m_fall = ~nxt & m_out;
      m_out  = nxt;
      m_s2   = m_s1;
      m_s1   = sw_raw;
    end
  end

  function automatic logic model_stable();
`ifdef SW_DEBOUNCE_EN
    // Quiet when the current sample and the one before the last edge both
    // match the accepted level (no count can be pending).
    return (m_s2 == m_out) && (exp_q[exp_q.size()-1] == m_out);
`else
    return (m_s2 == m_out);
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("cmp_sw_out",  32'(sw_out),  32'(m_out));
    chk("cmp_sw_rise", 32'(sw_rise), 32'(m_rise));
    chk("cmp_sw_fall", 32'(sw_fall), 32'(m_fall));
    chk("cmp_stable",  32'(stable),  32'(model_stable()));
  end

  // ---------------- observation capture ----------------
  logic [N-1:0] obs_out[16], obs_rise[16], obs_fall[16];
  logic [15:0]  obs_stable;

  task automatic grab(input int j);
    obs_out[j]    = sw_out;
    obs_rise[j]   = sw_rise;
    obs_fall[j]   = sw_fall;
    obs_stable[j] = stable;
  endtask

  task automatic run_edges(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      grab(j);
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset with all switches high: outputs cleared with no clock edge.
    sw_raw = '1;
    #1 n_reset = 1'b0;
    #1;
    chk("rst_sw_out",  32'(sw_out),  32'h0);
    chk("rst_sw_rise", 32'(sw_rise), 32'h0);
    chk("rst_sw_fall", 32'(sw_fall), 32'h0);
    chk("rst_stable",  32'(stable),  32'h1);
    repeat (3) @(negedge clk);
    sw_raw = '0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press and release of bit 3.
    sw_raw[3] = 1'b1;
    run_edges(8);
    chk("press_out_before", 32'(obs_out[LAT-1]),  32'h000);
    chk("press_out_at",     32'(obs_out[LAT]),    32'h008);
    chk("press_rise_at",    32'(obs_rise[LAT]),   32'h008);
    chk("press_rise_after", 32'(obs_rise[LAT+1]), 32'h000);
    sw_raw[3] = 1'b0;
    run_edges(8);
    chk("release_out_before", 32'(obs_out[LAT-1]), 32'h008);
    chk("release_fall_at",    32'(obs_fall[LAT]),  32'h008);
    chk("release_out_at",     32'(obs_out[LAT]),   32'h000);

    // Bounce on bit 0: 1,1,0,1,1,1,1 then held high.
    for (int j = 0; j < 12; j++) begin
      sw_raw[0] = (j < 7) ? pat[j] : 1'b1;
      @(negedge clk);
      grab(j);
    end
`ifdef SW_DEBOUNCE_EN
    chk("bounce_out_e7",  32'(obs_out[7][0]),  32'h0);
    chk("bounce_out_e8",  32'(obs_out[8][0]),  32'h1);
    chk("bounce_rise_e8", 32'(obs_rise[8][0]), 32'h1);
`else
    chk("bounce_out_e2",  32'(obs_out[2][0]),  32'h1);
    chk("bounce_out_e4",  32'(obs_out[4][0]),  32'h0);
    chk("bounce_fall_e4", 32'(obs_fall[4][0]), 32'h1);
    chk("bounce_out_e5",  32'(obs_out[5][0]),  32'h1);
`endif

    // Independent bits: bit 1 rises at edge 0, bit 2 at edge 2.
    for (int j = 0; j < 12; j++) begin
      if (j == 0) sw_raw[1] = 1'b1;
      if (j == 2) sw_raw[2] = 1'b1;
      @(negedge clk);
      grab(j);
    end
    chk("multi_rise1_before", 32'(obs_rise[LAT-1]), 32'h000);
    chk("multi_rise1_at",     32'(obs_rise[LAT]),   32'h002);
    chk("multi_rise_gap",     32'(obs_rise[LAT+1]), 32'h000);
    chk("multi_rise2_at",     32'(obs_rise[LAT+2]), 32'h004);
    sw_raw[1] = 1'b0;
    run_edges(8);
    chk("multi_fall1_at", 32'(obs_fall[LAT]), 32'h002);
    chk("multi_out_at",   32'(obs_out[LAT]),  32'h005);

    // Reset in the middle of counting bit 5.
    sw_raw[5] = 1'b1;
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("midrst_sw_out",  32'(sw_out),  32'h0);
    chk("midrst_sw_rise", 32'(sw_rise), 32'h0);
    chk("midrst_stable",  32'(stable),  32'h1);
    @(negedge clk);
    n_reset = 1'b1;
    run_edges(8);
    chk("midrst_out_before", 32'(obs_out[LAT-1]), 32'h000);
    chk("midrst_out_at",     32'(obs_out[LAT]),   32'h025);
    chk("midrst_rise_at",    32'(obs_rise[LAT]),  32'h025);

    // Bit 7 toggling every cycle.
    for (int j = 0; j < 12; j++) begin
      sw_raw[7] = ~sw_raw[7];
      @(negedge clk);
      grab(j);
    end
`ifdef SW_DEBOUNCE_EN
    for (int j = 2; j < 12; j++) begin
      chk("toggle_out7",  32'(obs_out[j][7]), 32'h0);
      chk("toggle_stable", 32'(obs_stable[j]), 32'h0);
    end
`else
    chk("toggle_out7_follow", 32'(obs_out[5][7]), 32'(obs_out[4][7] ^ 1'b1));
`endif

    // Everything low again: settles quiet.
    sw_raw = '0;
    run_edges(LAT + 4);
    chk("final_out",    32'(obs_out[LAT+3]),    32'h0);
    chk("final_stable", 32'(obs_stable[LAT+3]), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
